// File: rtl/gigatron_video_gen.sv
// Synthetic Gigatron video source: divides clk25 by 4 into clk1 and paints test
// patterns into Gigatron-format RGB/HSYNC/VSYNC, all updated on the clk1 rising edge.
module gigatron_video_gen #(
    parameter int H_TOTAL     = 200,
    parameter int H_SYNC      = 24,
    parameter int H_VIS_START = 36,
    parameter int H_VIS       = 160,
    parameter int V_TOTAL     = 521,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 26,
    parameter int V_VIS       = 480
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [5:0] solid_color,
    output logic       clk1,
    output logic [3:0] gigatron_vga_r,
    output logic [3:0] gigatron_vga_g,
    output logic [3:0] gigatron_vga_b,
    output logic       gigatron_vga_hs,
    output logic       gigatron_vga_vs,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
    localparam logic [9:0] H_VS_C   = 10'(H_VIS_START);
    localparam logic [9:0] H_VE_C   = 10'(H_VIS_START + H_VIS);
    localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0] V_VS_C   = 10'(V_VIS_START);
    localparam logic [9:0] V_VE_C   = 10'(V_VIS_START + V_VIS);

    logic [1:0] ph_r;
    logic       clk1_r;
    logic [9:0] col_r;
    logic [9:0] ln_r;
    logic [7:0] frame_cnt_r;
    logic [1:0] mode_r;
    logic [5:0] solid_r;
    logic       hs_r;
    logic       vs_r;
    logic       frame_start_r;
    logic [3:0] r_r;
    logic [3:0] g_r;
    logic [3:0] b_r;

    logic       tick_s;
    logic       advance_s;
    logic       origin_s;
    logic       col_wrap_s;
    logic       ln_wrap_s;
    logic       vis_s;
    logic [7:0] x_s;
    logic       row_b3_s;
    logic [5:0] grad_s;
    logic [1:0] mode_cur_s;
    logic [5:0] solid_cur_s;
    logic [5:0] color_s;

    assign tick_s     = (ph_r == 2'd3);
    assign advance_s  = tick_s & enable;
    assign origin_s   = (col_r == 10'd0) && (ln_r == 10'd0);
    assign col_wrap_s = (col_r == H_LAST_C);
    assign ln_wrap_s  = (ln_r == V_LAST_C);
    assign vis_s      = (col_r >= H_VS_C) && (col_r < H_VE_C) &&
                        (ln_r >= V_VS_C) && (ln_r < V_VE_C);
    assign x_s        = 8'(col_r - H_VS_C);
    // Bit 3 of the row index, where a row spans 4 lines
    assign row_b3_s   = 1'((ln_r - V_VS_C) >> 5);
    assign grad_s     = 6'(x_s + frame_cnt_r);

    // The origin pixel already uses the controls being latched on that edge
    assign mode_cur_s  = origin_s ? mode : mode_r;
    assign solid_cur_s = origin_s ? solid_color : solid_r;

    // Pattern colour {b,g,r} for the column being presented
    always_comb begin
        color_s = 6'h00;
        case (mode_cur_s)
            2'd0:    color_s = solid_cur_s;
            2'd1:    color_s = {x_s[7:5], x_s[7:5]};
            2'd2: begin
                if (x_s[3] ^ row_b3_s) begin
                    color_s = 6'h3F;
                end else begin
                    color_s = 6'h00;
                end
            end
            2'd3:    color_s = grad_s;
            default: color_s = 6'h00;
        endcase
    end

    // Phase counter; clk1 is high in phases 0 and 1
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            ph_r   <= 2'd0;
            clk1_r <= 1'b1;
        end else begin
            ph_r   <= ph_r + 2'd1;
            clk1_r <= (ph_r == 2'd3) || (ph_r == 2'd0);
        end
    end

    // Raster position and frame count advance once per enabled clk1 rising edge
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            col_r       <= 10'd0;
            ln_r        <= 10'd0;
            frame_cnt_r <= 8'd0;
        end else if (advance_s) begin
            if (col_wrap_s) begin
                col_r <= 10'd0;
                if (ln_wrap_s) begin
                    ln_r        <= 10'd0;
                    frame_cnt_r <= frame_cnt_r + 8'd1;
                end else begin
                    ln_r <= ln_r + 10'd1;
                end
            end else begin
                col_r <= col_r + 10'd1;
            end
        end
    end

    // Pattern controls are captured only at the frame origin
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            mode_r  <= 2'd0;
            solid_r <= 6'h00;
        end else if (advance_s && origin_s) begin
            mode_r  <= mode;
            solid_r <= solid_color;
        end
    end

    // Registered syncs and colour; idle levels while the generator is stopped
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            hs_r <= 1'b1;
            vs_r <= 1'b1;
            r_r  <= 4'h0;
            g_r  <= 4'h0;
            b_r  <= 4'h0;
        end else if (tick_s) begin
            if (enable) begin
                hs_r <= (col_r >= H_SYNC_C);
                vs_r <= (ln_r >= V_SYNC_C);
                if (vis_s) begin
                    r_r <= {color_s[1:0], 2'b00};
                    g_r <= {color_s[3:2], 2'b00};
                    b_r <= {color_s[5:4], 2'b00};
                end else begin
                    r_r <= 4'h0;
                    g_r <= 4'h0;
                    b_r <= 4'h0;
                end
            end else begin
                hs_r <= 1'b1;
                vs_r <= 1'b1;
                r_r  <= 4'h0;
                g_r  <= 4'h0;
                b_r  <= 4'h0;
            end
        end
    end

    // One clk25 strobe after the edge that presents the frame origin
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= advance_s && origin_s;
        end
    end

    assign clk1            = clk1_r;
    assign gigatron_vga_r  = r_r;
    assign gigatron_vga_g  = g_r;
    assign gigatron_vga_b  = b_r;
    assign gigatron_vga_hs = hs_r;
    assign gigatron_vga_vs = vs_r;
    assign frame_start     = frame_start_r;
    assign frame_cnt       = frame_cnt_r;

endmodule
